// File: rtl/aim_scheduler.sv
// aim_scheduler: sequencer for the 32-lane associative index-match engine.
//
// For each of (i_job_groups+1) weight groups it loads 32 weight channel
// indices from weight SRAM into a lane bank, launches the engine for
// (i_job_ite+1) activation chunks, keeps the first match position per lane,
// then streams (group, lane, pos) hit records downstream.
//
// Ports:
//   i_clk, i_rst_n                  clock, async active-low reset
//   i_job_valid/o_job_ready         job handshake (ready only in IDLE)
//   i_job_groups, i_job_ite         groups-1, iterations-1
//   o_wt_rd/o_wt_addr/i_wt_rdata    weight SRAM read port (1-cycle latency)
//   o_eng_start/o_eng_ite/o_eng_word engine launch and weight bank
//   i_eng_res_valid/i_eng_valid/i_eng_pos/i_eng_finish  engine results
//   o_hit_valid/i_hit_ready/o_hit_group/o_hit_lane/o_hit_pos/o_hit_miss
//                                   hit record stream
//   o_job_done                      one-cycle pulse at job end
//
// Build option: AIM_SCHED_MISS_EN -- when defined, DRAIN emits a record for
// every lane; miss lanes carry o_hit_miss=1 and o_hit_pos=0.

// Per-lane state: one weight word plus the sticky first-match flag/position.
module aim_sched_lane #(
  parameter int WORD_W = 16,
  parameter int POS_W  = 9
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic              i_clr,
  input  logic              i_cap,
  input  logic              i_valid,
  input  logic [POS_W-1:0]  i_pos,
  output logic [WORD_W-1:0] o_word,
  output logic              o_hit,
  output logic [POS_W-1:0]  o_pos
);
  logic [WORD_W-1:0] word_q, word_d;
  logic              hit_q, hit_d;
  logic [POS_W-1:0]  pos_q, pos_d;

  always_comb begin
    word_d = word_q;
    hit_d  = hit_q;
    pos_d  = pos_q;
    if (i_wr) word_d = i_wdata;
    if (i_clr) begin
      hit_d = 1'b0;
    end else if (i_cap && i_valid && !hit_q) begin
      // First (lowest-iteration) match sticks; later ones are ignored.
      hit_d = 1'b1;
      pos_d = i_pos;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      word_q <= '0;
      hit_q  <= 1'b0;
      pos_q  <= '0;
    end else begin
      word_q <= word_d;
      hit_q  <= hit_d;
      pos_q  <= pos_d;
    end
  end

  assign o_word = word_q;
  assign o_hit  = hit_q;
  assign o_pos  = pos_q;
endmodule

module aim_scheduler #(
  parameter int N_LANE = 32,
  parameter int WORD_W = 16,
  parameter int POS_W  = 9,
  parameter int GRP_W  = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_job_valid,
  output logic                     o_job_ready,
  input  logic [GRP_W-1:0]         i_job_groups,
  input  logic [2:0]               i_job_ite,
  output logic                     o_wt_rd,
  output logic [GRP_W+4:0]         o_wt_addr,
  input  logic [WORD_W-1:0]        i_wt_rdata,
  output logic                     o_eng_start,
  output logic [2:0]               o_eng_ite,
  output logic [N_LANE*WORD_W-1:0] o_eng_word,
  input  logic                     i_eng_res_valid,
  input  logic [N_LANE-1:0]        i_eng_valid,
  input  logic [N_LANE*POS_W-1:0]  i_eng_pos,
  input  logic                     i_eng_finish,
  output logic                     o_hit_valid,
  input  logic                     i_hit_ready,
  output logic [GRP_W-1:0]         o_hit_group,
  output logic [4:0]               o_hit_lane,
  output logic [POS_W-1:0]         o_hit_pos,
  output logic                     o_hit_miss,
  output logic                     o_job_done
);
  typedef enum logic [2:0] {IDLE, LOAD, START, RUN, DRAIN, NEXT} state_e;

  state_e             state_q, state_d;
  logic [GRP_W-1:0]   groups_q, groups_d;
  logic [GRP_W-1:0]   grp_q, grp_d;
  logic [2:0]         ite_q, ite_d;
  logic [5:0]         cnt_q, cnt_d;   // LOAD cycle 0..32
  logic [4:0]         ptr_q, ptr_d;   // DRAIN lane pointer

  logic                               clr;
  logic                               cap;
  logic                               adv;
  logic                               drain;
  logic                               cur_hit;
  logic [POS_W-1:0]                   cur_pos;
  logic [N_LANE-1:0][WORD_W-1:0]      bank;
  logic [N_LANE-1:0]                  lane_hit;
  logic [N_LANE-1:0][POS_W-1:0]       lane_pos;

  // Read data for address k lands one cycle later, i.e. at LOAD count k+1.
  for (genvar k = 0; k < N_LANE; k++) begin : g_lane
    aim_sched_lane #(.WORD_W(WORD_W), .POS_W(POS_W)) u_lane (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_wr    (state_q == LOAD && cnt_q == 6'(k + 1)),
      .i_wdata (i_wt_rdata),
      .i_clr   (clr),
      .i_cap   (cap),
      .i_valid (i_eng_valid[k]),
      .i_pos   (i_eng_pos[k*POS_W +: POS_W]),
      .o_word  (bank[k]),
      .o_hit   (lane_hit[k]),
      .o_pos   (lane_pos[k])
    );
  end

  assign drain   = (state_q == DRAIN);
  assign cur_hit = lane_hit[ptr_q];
  assign cur_pos = lane_pos[ptr_q];
  assign cap     = (state_q == RUN) && i_eng_res_valid;

  always_comb begin
`ifdef AIM_SCHED_MISS_EN
    o_hit_valid = drain;
    o_hit_miss  = drain && !cur_hit;
    o_hit_pos   = (drain && cur_hit) ? cur_pos : '0;
    adv         = i_hit_ready;
`else
    o_hit_valid = drain && cur_hit;
    o_hit_miss  = 1'b0;
    o_hit_pos   = drain ? cur_pos : '0;
    adv         = !cur_hit || i_hit_ready;
`endif
  end

  always_comb begin
    state_d  = state_q;
    groups_d = groups_q;
    grp_d    = grp_q;
    ite_d    = ite_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    clr      = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_job_valid) begin
          groups_d = i_job_groups;
          ite_d    = i_job_ite;
          grp_d    = '0;
          cnt_d    = '0;
          clr      = 1'b1;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        if (cnt_q == 6'd32) begin
          cnt_d   = '0;
          state_d = START;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      START: begin
        clr     = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        // Capture of a coincident res_valid happens in the lanes this cycle.
        if (i_eng_finish) begin
          ptr_d   = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (adv) begin
          if (ptr_q == 5'd31) state_d = NEXT;
          else                ptr_d   = ptr_q + 5'd1;
        end
      end
      NEXT: begin
        if (grp_q == groups_q) begin
          state_d = IDLE;
        end else begin
          grp_d   = grp_q + 1'b1;
          cnt_d   = '0;
          state_d = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      groups_q <= '0;
      grp_q    <= '0;
      ite_q    <= '0;
      cnt_q    <= '0;
      ptr_q    <= '0;
    end else begin
      state_q  <= state_d;
      groups_q <= groups_d;
      grp_q    <= grp_d;
      ite_q    <= ite_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
    end
  end

  assign o_job_ready = (state_q == IDLE);
  assign o_wt_rd     = (state_q == LOAD) && !cnt_q[5];
  assign o_wt_addr   = (state_q == LOAD) ? {grp_q, cnt_q[4:0]} : '0;
  assign o_eng_start = (state_q == START);
  assign o_eng_ite   = ite_q;
  assign o_eng_word  = bank;
  assign o_hit_group = drain ? grp_q : '0;
  assign o_hit_lane  = drain ? ptr_q : '0;
  assign o_job_done  = (state_q == NEXT) && (grp_q == groups_q);
endmodule

// File: doc/aim_scheduler.md
Name: aim_scheduler

Overview:
- Sequencer for the 32-lane associative index-match engine.
- Accepts a job of G weight groups of 32 words each. For every group it:
  - loads the 32 weight channel indices from weight SRAM into a register bank;
  - launches the engine for (ite+1) input-activation chunks;
  - records per-lane match positions;
  - streams hits as (group, lane, pos) records to the downstream MAC address generator.

Parameters:
- N_LANE, 32, lanes per group; fixed to the engine width.
- WORD_W, 16, weight channel index width.
- POS_W, 9, match position width (ite*32 + bit index).
- GRP_W, 4, group count width; max job = 2^GRP_W groups.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset
- i_job_valid  in  1  job request
- o_job_ready  out  1  high only in IDLE
- i_job_groups  in  GRP_W  number of groups minus 1
- i_job_ite  in  3  iterations minus 1, passed to engine
- o_wt_rd  out  1  weight SRAM read strobe
- o_wt_addr  out  GRP_W+5  weight address = group*32 + lane
- i_wt_rdata  in  WORD_W  read data, valid 1 cycle after o_wt_rd
- o_eng_start  out  1  one-cycle engine start pulse
- o_eng_ite  out  3  latched i_job_ite
- o_eng_word  out  N_LANE*WORD_W  weight bank; lane k = bits [k*WORD_W +: WORD_W]
- i_eng_res_valid  in  1  engine per-iteration result strobe
- i_eng_valid  in  N_LANE  per-lane hit flags, sampled on i_eng_res_valid
- i_eng_pos  in  N_LANE*POS_W  per-lane positions, sampled on i_eng_res_valid
- i_eng_finish  in  1  engine completion pulse
- o_hit_valid  out  1  record valid
- i_hit_ready  in  1  downstream accept
- o_hit_group  out  GRP_W  group index
- o_hit_lane  out  5  lane index
- o_hit_pos  out  POS_W  match position
- o_hit_miss  out  1  miss record flag (see Optional Feature)
- o_job_done  out  1  one-cycle pulse at job end

Behaviour:
- Reset:
  - Reset i_rst_n, asynchronous, active-low; clock i_clk.
  - On reset: state IDLE, all outputs 0 except o_job_ready=1; weight bank, hit-flag and position registers cleared.
- States: IDLE, LOAD, START, RUN, DRAIN, NEXT.
- IDLE:
  - Job accepted on i_job_valid && o_job_ready.
  - On accept: latch groups and ite, group counter := 0, lane hit flags := 0, go to LOAD.
- LOAD:
  - o_wt_rd=1 for exactly 32 consecutive cycles, addresses group*32+0 .. group*32+31.
  - i_wt_rdata written to lane k one cycle after address k is issued.
  - LOAD lasts 33 cycles, then go to START.
- START:
  - o_eng_start=1 for one cycle; o_eng_word and o_eng_ite stay stable until RUN exits.
  - Clear lane hit flags; go to RUN.
- RUN:
  - On each i_eng_res_valid, for every lane with i_eng_valid=1 and hit flag=0: set flag, store pos.
  - The first (lowest-iteration) match is sticky; later matches on the same lane are ignored.
  - On i_eng_finish go to DRAIN. If res_valid coincides with finish, capture first, then leave.
  - Pulses arriving outside RUN are ignored.
- DRAIN:
  - Lane pointer scans 0..31.
  - Miss lane: skipped in 1 cycle, no record.
  - Hit lane: o_hit_valid=1 with group/lane/pos. Fields are held stable until i_hit_ready; the pointer advances on the handshake.
  - i_hit_ready low stalls indefinitely.
  - After lane 31 is done, go to NEXT.
  - Total cycles = 32 + stall cycles.
- NEXT:
  - If group == latched groups: o_job_done=1 for one cycle, go to IDLE.
  - Otherwise group++ and go to LOAD.
- Widths:
  - Address = {group, lane[4:0]}; no overflow possible.
  - o_hit_pos is passed through unmodified.
- Reset mid-operation:
  - Immediate return to IDLE with no o_job_done and any in-flight record dropped.
  - The engine is not notified; it finishes on its own, and its pulses are ignored.
- i_job_valid outside IDLE is ignored (o_job_ready=0).

Optional Feature:
- Macro: AIM_SCHED_MISS_EN.
- Defined:
  - DRAIN emits a record for every lane, 32 per group.
  - Miss lanes carry o_hit_miss=1 and o_hit_pos=0, and use the same handshake.
- Undefined:
  - Miss lanes are skipped.
  - o_hit_miss is tied to 0.

Test Plan:
- Weight mem[a]=a; groups=0, ite=1; engine model reports lane 3 hit pos 37 on iteration 1 only -> exactly one record (0,3,37), then o_job_done. LOAD reads addresses 0..31 over 32 consecutive cycles.
- Lane 5 hit pos 2 in iteration 0 and pos 40 in iteration 1 -> single record (0,5,2).
- Lane 0 hit, i_hit_ready held low 10 cycles -> o_hit_valid high with (0,0,pos) stable for all 10 cycles; exactly one record after ready rises.
- groups=1 -> second LOAD reads addresses 32..63; records tagged group 1; one o_job_done after group 1 drains.
- Reset asserted in RUN -> outputs return to reset values; stray i_eng_finish after reset produces no record or done; a new job then completes normally.
- With AIM_SCHED_MISS_EN and no engine hits -> 32 records, lanes 0..31 in order, o_hit_miss=1, pos=0.
